// File: rtl/dircc_types_pkg.sv
// dircc_types_pkg: shared DiRCC packet layout and the send-arbiter state encoding.
package dircc_types_pkg;
  typedef struct packed {
    logic [15:0] hw_addr;
    logic [15:0] sw_addr;
  } addr_t;
  typedef struct packed {
    addr_t       dest;
    addr_t       src;
    logic [63:0] payload;
  } packet_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} arb_state_t;
endpackage

// File: rtl/dircc_rr_select.sv
// dircc_rr_select: combinational round-robin pick, first set req at or after rr_ptr with wrap.
module dircc_rr_select #(
  parameter  int NUM_REQ   = 4,
  localparam int PTR_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [PTR_WIDTH-1:0] rr_ptr,
  output logic [PTR_WIDTH-1:0] winner,
  output logic                 valid
);
  always_comb begin
    winner = '0;
    valid  = |req;
    // Walk farthest-first so the nearest set request overwrites last.
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[(int'(rr_ptr) + i) % NUM_REQ]) winner = PTR_WIDTH'((int'(rr_ptr) + i) % NUM_REQ);
  end
endmodule

// File: rtl/dircc_packet_send_arbiter.sv
// dircc_packet_send_arbiter: round-robin share of one Avalon-ST packet sender between NUM_REQ
// requesters; issues write_packet, tracks tx_sending, reports done or a start timeout.
module dircc_packet_send_arbiter
  import dircc_types_pkg::*;
#(
  parameter  int NUM_REQ       = 4,
  parameter  int START_TIMEOUT = 4,
  localparam int PTR_WIDTH     = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  packet_t            req_packet [NUM_REQ],
  output logic [NUM_REQ-1:0] grant_ack,
  output logic [NUM_REQ-1:0] done,
  output logic               timeout_err,
  output logic               busy,
  output logic               tx_write_packet,
  output packet_t            tx_packet_data,
  input  logic               tx_sending
);
  arb_state_t           state_q, state_d;
  logic [PTR_WIDTH-1:0] rr_ptr_q, rr_ptr_d, owner_q, owner_d, winner;
  logic [7:0]           tout_cnt_q, tout_cnt_d;
  logic                 tx_write_q, tx_write_d, timeout_err_q, timeout_err_d, valid;
  packet_t              tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0]   grant_ack_q, grant_ack_d, done_q, done_d;

  dircc_rr_select #(.NUM_REQ(NUM_REQ)) u_sel (
    .req(req), .rr_ptr(rr_ptr_q), .winner(winner), .valid(valid)
  );

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    tout_cnt_d    = tout_cnt_q;
    tx_write_d    = 1'b0;
    tx_data_d     = tx_data_q;
    grant_ack_d   = '0;
    done_d        = '0;
    timeout_err_d = 1'b0;
    case (state_q)
      IDLE:
        // A busy sender here is someone else's transfer; never grant into it.
        if (valid && !tx_sending) begin
          tx_data_d   = req_packet[winner];
          tx_write_d  = 1'b1;
          grant_ack_d = NUM_REQ'(1) << winner;
          owner_d     = winner;
          rr_ptr_d    = (winner == PTR_WIDTH'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
          state_d     = ISSUE;
        end
      ISSUE: begin
        tout_cnt_d = '0;
        state_d    = WAIT_START;
      end
      WAIT_START:
        if (tx_sending) state_d = WAIT_DONE;
        else if (tout_cnt_q == 8'(START_TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else tout_cnt_d = tout_cnt_q + 8'd1;
      WAIT_DONE:
        if (!tx_sending) begin
          done_d[owner_q] = 1'b1;
          state_d         = IDLE;
        end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      tout_cnt_q    <= '0;
      tx_write_q    <= 1'b0;
      tx_data_q     <= '0;
      grant_ack_q   <= '0;
      done_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      tout_cnt_q    <= tout_cnt_d;
      tx_write_q    <= tx_write_d;
      tx_data_q     <= tx_data_d;
      grant_ack_q   <= grant_ack_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
    end

  assign busy            = state_q != IDLE;
  assign tx_write_packet = tx_write_q;
  assign tx_packet_data  = tx_data_q;
  assign grant_ack       = grant_ack_q;
  assign done            = done_q;
  assign timeout_err     = timeout_err_q;
endmodule

// File: tb/tb_dircc_packet_send_arbiter.sv
// tb_dircc_packet_send_arbiter: directed and random transactions against a transaction-level
// round-robin model and an 8-beat sender stub with stall and dead modes.
module tb_dircc_packet_send_arbiter;
  import dircc_types_pkg::*;
  localparam int N = 4, TOUT = 4;
  logic clk = 0, reset_n = 0, ready = 1, dead = 0, sending;
  logic [N-1:0] req = '0, grant_ack, done;
  logic timeout_err, busy, tx_write_packet;
  packet_t pkt [N];
  packet_t tx_packet_data;
  int beats, cyc = 0, errors = 0, checks = 0, mptr = 0;

  dircc_packet_send_arbiter #(.NUM_REQ(N), .START_TIMEOUT(TOUT)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_packet(pkt), .grant_ack(grant_ack),
    .done(done), .timeout_err(timeout_err), .busy(busy), .tx_write_packet(tx_write_packet),
    .tx_packet_data(tx_packet_data), .tx_sending(sending)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Sender stub: accepts write_packet while idle, then sends 8 beats advancing only when ready.
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sending <= 0;
      beats   <= 0;
    end else if (!sending) begin
      if (tx_write_packet && !dead) begin
        sending <= 1;
        beats   <= 0;
      end
    end else if (ready) begin
      if (beats == 7) sending <= 0;
      else beats <= beats + 1;
    end

  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++) if (m[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  function automatic packet_t rand_pkt();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic wait_grant(output int w, output int gcyc);
    logic [N-1:0] e;
    bit got = 0;
    w = pick(req, mptr);
    e = N'(1) << w;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = grant_ack != 0;
    end
    gcyc = cyc;
    chk("grant_ack", grant_ack, e);
    chk("write_pulse", tx_write_packet, 1);
    chk("packet_data", tx_packet_data, pkt[w]);
    chk("busy_issue", busy, 1);
    mptr = (w + 1) % N;
  endtask

  task automatic do_xfer(input int stall, input bit keep, output int gcyc);
    int w, k;
    bit stray = 0, nb = 0;
    packet_t sent;
    logic [N-1:0] e;
    wait_grant(w, gcyc);
    sent = pkt[w];
    e = N'(1) << w;
    if (!keep) req[w] = 0;
    @(negedge clk);
    chk("write_one_cycle", tx_write_packet, 0);
    chk("grant_one_cycle", grant_ack, 0);
    ready = stall == 0;
    k = 0;
    while (done == 0 && k < 60) begin
      @(negedge clk);
      k++;
      if (k >= stall) ready = 1;
      if (done == 0) begin
        if (grant_ack != 0) stray = 1;
        if (!busy) nb = 1;
      end
    end
    ready = 1;
    chk("done_owner", done, e);
    chk("done_latency", cyc - gcyc, 10 + stall);
    chk("no_stray_grant", stray, 0);
    chk("busy_held", nb, 0);
    chk("busy_after_done", busy, 0);
    chk("data_held", tx_packet_data, sent);
  endtask

  initial begin
    int g, prev, w, k;
    bit seen_done;
    for (int i = 0; i < N; i++) pkt[i] = rand_pkt();
    repeat (3) @(negedge clk);
    chk("rst_grant", grant_ack, 0);
    chk("rst_done", done, 0);
    chk("rst_write", tx_write_packet, 0);
    chk("rst_data", tx_packet_data, 0);
    chk("rst_busy", busy, 0);
    reset_n = 1;
    @(negedge clk);
    // Single requester with a known destination.
    pkt[2].dest.hw_addr = 16'h11;
    req = 4'b0100;
    do_xfer(0, 0, g);
    // Pointer now sits at 3: 3 first, then 1, with 3 re-requesting straight away.
    req = 4'b1010;
    do_xfer(0, 0, g);
    req[3] = 1;
    pkt[3] = rand_pkt();
    do_xfer(0, 0, g);
    do_xfer(0, 0, g);
    // All four held: strict rotation, 11-cycle grant spacing.
    req = 4'b1111;
    do_xfer(0, 1, prev);
    for (int i = 0; i < 4; i++) begin
      do_xfer(0, 1, g);
      chk("grant_spacing", g - prev, 11);
      prev = g;
    end
    // Long stall mid-packet with others waiting.
    do_xfer(20, 1, g);
    req = '0;
    @(negedge clk);
    // Random traffic.
    for (int i = 0; i < 12; i++) begin
      logic [N-1:0] add = N'($urandom);
      for (int b = 0; b < N; b++) if (add[b] && !req[b]) pkt[b] = rand_pkt();
      req |= add;
      if (req == 0) req = 4'b0001;
      do_xfer($urandom_range(0, 6), 0, g);
    end
    req = '0;
    @(negedge clk);
    // Sender never starts.
    dead = 1;
    req = 4'b0110;
    wait_grant(w, g);
    req[w] = 0;
    seen_done = 0;
    k = 0;
    while (!timeout_err && k < 20) begin
      @(negedge clk);
      k++;
      if (done != 0) seen_done = 1;
    end
    chk("timeout_latency", cyc - g, TOUT + 1);
    chk("timeout_no_done", seen_done, 0);
    dead = 0;
    do_xfer(0, 0, g);
    chk("timeout_cleared", timeout_err, 0);
    // Reset in WAIT_DONE during beat 4.
    req = 4'b0100;
    pkt[2] = rand_pkt();
    wait_grant(w, g);
    req = '0;
    k = 0;
    while (!(sending && beats == 4) && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("reached_beat4", beats, 4);
    reset_n = 0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_data", tx_packet_data, 0);
    chk("mrst_sending", sending, 0);
    @(negedge clk);
    chk("mrst_done", done, 0);
    chk("mrst_grant", grant_ack, 0);
    chk("mrst_timeout", timeout_err, 0);
    mptr = 0;
    req = 4'b0001;
    reset_n = 1;
    do_xfer(0, 0, g);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
